init_sequencer: RTL and testbench

//  Power-up sequencer and write-port arbiter for the text-mode video path.

---
 rtl/init_sequencer.sv | 124 ++++++++++++
 tb/tb_init_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/init_sequencer.sv
// Power-up sequencer for the text-mode video path: holds the video pipeline in
// reset, fills the character RAM with FILL_CHAR, then passes the write port to the user.
module init_sequencer #(
  parameter int                HOLD_CYCLES = 16,
  parameter int                ADDR_W      = 11,
  parameter int                DEPTH       = 1200,
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] FILL_CHAR   = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic              usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_data,
  output logic              usr_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              sub_rst,
  output logic              blank,
  output logic              done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state,    state_next;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_next;
  logic                ram_we_next;
  logic [ADDR_W-1:0]   ram_addr_next;
  logic [DATA_W-1:0]   ram_data_next;
  logic                done_next;

  // Status outputs decode straight from the state so they track it with no lag.
  assign usr_ready = (state == ST_RUN);
  assign sub_rst   = (state == ST_HOLD);
  assign blank     = (state != ST_RUN);

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    clr_addr_next = clr_addr;
    ram_we_next   = 1'b0;
    ram_addr_next = ram_addr;
    ram_data_next = ram_data;
    done_next     = done;

    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next    = ST_CLEAR;
          hold_cnt_next = '0;
          clr_addr_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end

      ST_CLEAR: begin
        // User writes and clear requests are dropped here, not queued.
        ram_we_next   = 1'b1;
        ram_addr_next = clr_addr;
        ram_data_next = FILL_CHAR;
        if (clr_addr == ADDR_LAST) begin
          state_next    = ST_RUN;
          done_next     = 1'b1;
          clr_addr_next = '0;
        end else begin
          clr_addr_next = clr_addr + 1'b1;
        end
      end

      ST_RUN: begin
        ram_we_next   = usr_we;
        ram_addr_next = usr_addr;
        ram_data_next = usr_data;
        // The user write still lands this cycle; the clear then overwrites it.
        if (clear_req) begin
          state_next    = ST_CLEAR;
          clr_addr_next = '0;
        end
      end

      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      clr_addr <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      clr_addr <= clr_addr_next;
      ram_we   <= ram_we_next;
      ram_addr <= ram_addr_next;
      ram_data <= ram_data_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: one instance with HOLD_CYCLES=4/DEPTH=8,
// one with HOLD_CYCLES=1/DEPTH=1, sharing clock and user inputs.
module tb_init_sequencer;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_a = 1'b1;
  logic          rst_b = 1'b1;
  logic          clear_req = 1'b0;
  logic          usr_we = 1'b0;
  logic [AW-1:0] usr_addr = '0;
  logic [DW-1:0] usr_data = '0;

  logic          usr_ready_a, ram_we_a, sub_rst_a, blank_a, done_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          usr_ready_b, ram_we_b, sub_rst_b, blank_b, done_b;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  init_sequencer #(
    .HOLD_CYCLES(4), .ADDR_W(AW), .DEPTH(8), .DATA_W(DW), .FILL_CHAR(8'h20)
  ) dut_a (
    .clk(clk), .rst(rst_a), .clear_req(clear_req), .usr_we(usr_we),
    .usr_addr(usr_addr), .usr_data(usr_data), .usr_ready(usr_ready_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .sub_rst(sub_rst_a), .blank(blank_a), .done(done_a)
  );

  init_sequencer #(
    .HOLD_CYCLES(1), .ADDR_W(AW), .DEPTH(1), .DATA_W(DW), .FILL_CHAR(8'h20)
  ) dut_b (
    .clk(clk), .rst(rst_b), .clear_req(clear_req), .usr_we(usr_we),
    .usr_addr(usr_addr), .usr_data(usr_data), .usr_ready(usr_ready_b),
    .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .sub_rst(sub_rst_b), .blank(blank_b), .done(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_sub_rst"},   32'(sub_rst_a),   32'd1);
    check({tag, "_blank"},     32'(blank_a),     32'd1);
    check({tag, "_done"},      32'(done_a),      32'd0);
    check({tag, "_usr_ready"}, 32'(usr_ready_a), 32'd0);
    check({tag, "_ram_we"},    32'(ram_we_a),    32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr_a),  32'd0);
    check({tag, "_ram_data"},  32'(ram_data_a),  32'd0);
  endtask

  // Called right after the edge where rst_a was released; a user write is
  // held active throughout the clear and must never reach the RAM port.
  task automatic init_a(input string tag);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("%s_hold%0d_sub_rst", tag, i), 32'(sub_rst_a), 32'd1);
      check($sformatf("%s_hold%0d_ram_we", tag, i),  32'(ram_we_a),  32'd0);
    end
    tick();
    check({tag, "_enter_clear_sub_rst"}, 32'(sub_rst_a), 32'd0);
    check({tag, "_enter_clear_blank"},   32'(blank_a),   32'd1);
    check({tag, "_enter_clear_ram_we"},  32'(ram_we_a),  32'd0);
    usr_we   = 1'b1;
    usr_addr = 4'd3;
    usr_data = 8'h7F;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("%s_clr%0d_we", tag, i),   32'(ram_we_a),   32'd1);
      check($sformatf("%s_clr%0d_addr", tag, i), 32'(ram_addr_a), 32'(i));
      check($sformatf("%s_clr%0d_data", tag, i), 32'(ram_data_a), 32'h20);
      if (i < 7) begin
        check($sformatf("%s_clr%0d_ready", tag, i), 32'(usr_ready_a), 32'd0);
        check($sformatf("%s_clr%0d_done", tag, i),  32'(done_a),      32'd0);
      end
    end
    usr_we = 1'b0;
    check({tag, "_run_done"},    32'(done_a),      32'd1);
    check({tag, "_run_ready"},   32'(usr_ready_a), 32'd1);
    check({tag, "_run_blank"},   32'(blank_a),     32'd0);
    check({tag, "_run_sub_rst"}, 32'(sub_rst_a),   32'd0);
    tick();
    check({tag, "_run_idle_we"}, 32'(ram_we_a), 32'd0);
  endtask

  initial begin
    // Power-up reset of instance A.
    tick();
    tick();
    check_reset_a("rst0");
    rst_a = 1'b0;
    init_a("init1");

    // Plain user write, then idle.
    usr_we = 1'b1; usr_addr = 4'd5; usr_data = 8'h41;
    tick();
    check("wr_we",   32'(ram_we_a),   32'd1);
    check("wr_addr", 32'(ram_addr_a), 32'd5);
    check("wr_data", 32'(ram_data_a), 32'h41);
    usr_we = 1'b0;
    tick();
    check("wr_idle_we", 32'(ram_we_a), 32'd0);

    // Clear request together with a user write; a second request mid-clear is dropped.
    usr_we = 1'b1; usr_addr = 4'd2; usr_data = 8'h55; clear_req = 1'b1;
    tick();
    usr_we = 1'b0; clear_req = 1'b0;
    check("rc_wr_we",    32'(ram_we_a),    32'd1);
    check("rc_wr_addr",  32'(ram_addr_a),  32'd2);
    check("rc_wr_data",  32'(ram_data_a),  32'h55);
    check("rc_blank",    32'(blank_a),     32'd1);
    check("rc_sub_rst",  32'(sub_rst_a),   32'd0);
    check("rc_ready",    32'(usr_ready_a), 32'd0);
    check("rc_done",     32'(done_a),      32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      clear_req = (i == 2);
      check($sformatf("rc%0d_we", i),   32'(ram_we_a),   32'd1);
      check($sformatf("rc%0d_addr", i), 32'(ram_addr_a), 32'(i));
      check($sformatf("rc%0d_data", i), 32'(ram_data_a), 32'h20);
      if (i < 7) begin
        check($sformatf("rc%0d_blank", i),   32'(blank_a),   32'd1);
        check($sformatf("rc%0d_sub_rst", i), 32'(sub_rst_a), 32'd0);
        check($sformatf("rc%0d_done", i),    32'(done_a),    32'd1);
      end
    end
    clear_req = 1'b0;
    check("rc_end_ready", 32'(usr_ready_a), 32'd1);
    tick();
    check("rc_no_requeue_we",    32'(ram_we_a),    32'd0);
    check("rc_no_requeue_ready", 32'(usr_ready_a), 32'd1);

    // Asynchronous reset while clr_addr==4, then the full sequence repeats.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (4) tick();
    check("pre_rst_addr", 32'(ram_addr_a), 32'd3);
    #2;
    rst_a = 1'b1;
    #1;
    check_reset_a("async");
    tick();
    rst_a = 1'b0;
    init_a("init2");

    // Instance B: single-cycle hold and single-cell clear.
    check("b_rst_sub_rst", 32'(sub_rst_b), 32'd1);
    check("b_rst_done",    32'(done_b),    32'd0);
    rst_b = 1'b0;
    tick();
    check("b_clear_sub_rst", 32'(sub_rst_b),   32'd0);
    check("b_clear_blank",   32'(blank_b),     32'd1);
    check("b_clear_we",      32'(ram_we_b),    32'd0);
    tick();
    check("b_fill_we",    32'(ram_we_b),    32'd1);
    check("b_fill_addr",  32'(ram_addr_b),  32'd0);
    check("b_fill_data",  32'(ram_data_b),  32'h20);
    check("b_run_done",   32'(done_b),      32'd1);
    check("b_run_ready",  32'(usr_ready_b), 32'd1);
    check("b_run_blank",  32'(blank_b),     32'd0);
    tick();
    check("b_idle_we", 32'(ram_we_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
